// File: rtl/serdesphy_pcs_pkg.sv
// Shared definitions for the PCS TX lane.
// Holds:
//   src_sel_e        - word source chosen at each load (FIFO, PRBS, idle pattern)
//   PRBS7_SEED       - PRBS7 register value after reset
//   PRBS7_TAP_HI/LO  - feedback taps of x^7 + x^6 + 1 (0-based state bit indices)
//   DEFAULT_IDLE_PAT - idle word, sliced to the lane width by the top
//   prbs7_next()     - one PRBS7 step; the newly generated bit lands in bit 0
package serdesphy_pcs_pkg;

    typedef enum logic [1:0] {
        SRC_FIFO,
        SRC_PRBS,
        SRC_IDLE
    } src_sel_e;

    localparam logic [6:0]  PRBS7_SEED       = 7'h7F;
    localparam int unsigned PRBS7_TAP_HI     = 6;
    localparam int unsigned PRBS7_TAP_LO     = 5;
    localparam logic [15:0] DEFAULT_IDLE_PAT = 16'h000A;

    function automatic logic [6:0] prbs7_next(input logic [6:0] state);
        return {state[5:0], state[PRBS7_TAP_HI] ^ state[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/serdesphy_sync_fifo.sv
// Single-clock FIFO that buffers parallel words for the TX lane.
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset (empties the FIFO)
//   wr_en_i    - push request; ignored while full
//   wr_data_i  - word to push
//   rd_en_i    - pop request; ignored while empty
//   rd_data_o  - head word (valid whenever empty_o is low)
//   full_o     - occupancy equals FIFO_DEPTH
//   empty_o    - occupancy is zero
//   level_o    - current occupancy
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module serdesphy_sync_fifo #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          rd_en_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              push, pop;

    assign full_o    = (level_q == LvlW'(FIFO_DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        push     = wr_en_i && !full_o;
        pop      = rd_en_i && !empty_o;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/serdesphy_pcs_tx_lane.sv
// PCS TX lane: buffers parallel words in a FIFO and serialises them LSB first,
// one bit per clock, substituting the idle pattern or a PRBS7 word on request.
// Ports:
//   clk_240m_tx / rst_240m_tx       - bit clock, synchronous active-high reset
//   tx_en                           - lane enable (stops only at a word boundary)
//   tx_idle                         - force the idle pattern at the next load
//   tx_data_sel                     - source at the next load: 0=FIFO, 1=PRBS
//   clr_sticky                      - clear overflow/underflow (a same-cycle set wins)
//   tx_data / tx_valid / tx_ready   - FIFO write port; tx_ready = !tx_fifo_full
//   tx_serial_data / tx_serial_valid - serial bit and its qualifier
//   tx_idle_pattern                 - the word on the line came from the idle pattern
//   tx_fifo_full / tx_fifo_empty / tx_fifo_level - FIFO status
//   tx_overflow / tx_underflow      - sticky error flags
//   tx_active                       - shifter is in the SHIFT state
// Build option: define SERDESPHY_TX_PRBS_EN to include the PRBS7 generator;
// without it, tx_data_sel=1 loads the idle pattern.
module serdesphy_pcs_tx_lane
    import serdesphy_pcs_pkg::*;
#(
    parameter int unsigned       DATA_W     = 4,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] IDLE_PAT   = DEFAULT_IDLE_PAT[DATA_W-1:0]
) (
    input  logic                        clk_240m_tx,
    input  logic                        rst_240m_tx,
    input  logic                        tx_en,
    input  logic                        tx_idle,
    input  logic                        tx_data_sel,
    input  logic                        clr_sticky,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_serial_data,
    output logic                        tx_serial_valid,
    output logic                        tx_idle_pattern,
    output logic                        tx_fifo_full,
    output logic                        tx_fifo_empty,
    output logic                        tx_overflow,
    output logic                        tx_underflow,
    output logic                        tx_active,
    output logic [$clog2(FIFO_DEPTH):0] tx_fifo_level
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              idle_word_q, idle_word_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              popped_q, popped_d;
    logic              tx_en_q;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_pop;
    src_sel_e          src_sel;
    logic              word_end, load, popped_eff, underflow_set;

    serdesphy_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_240m_tx),
        .rst_i     (rst_240m_tx),
        .wr_en_i   (tx_valid),
        .wr_data_i (tx_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (tx_fifo_full),
        .empty_o   (tx_fifo_empty),
        .level_o   (tx_fifo_level)
    );

`ifdef SERDESPHY_TX_PRBS_EN
    logic [6:0]        prbs_q, prbs_d, prbs_adv;
    logic [DATA_W-1:0] prbs_word;

    // Run DATA_W steps ahead; the first generated bit goes out first.
    always_comb begin
        prbs_adv  = prbs_q;
        prbs_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            prbs_adv     = prbs7_next(prbs_adv);
            prbs_word[i] = prbs_adv[0];
        end
    end

    always_ff @(posedge clk_240m_tx) begin
        if (rst_240m_tx) begin
            prbs_q <= PRBS7_SEED;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        idle_word_d   = idle_word_q;
        fifo_pop      = 1'b0;
        underflow_set = 1'b0;
`ifdef SERDESPHY_TX_PRBS_EN
        prbs_d        = prbs_q;
`endif
        word_end = (state_q == StShift) && (bit_cnt_q == CntW'(DATA_W - 1));
        load     = tx_en && ((state_q == StIdle) || word_end);
        // Underflow only counts once this enable period has popped a word.
        popped_eff = popped_q && !(tx_en && !tx_en_q);

        if (tx_idle) begin
            src_sel = SRC_IDLE;
        end else if (tx_data_sel) begin
            src_sel = SRC_PRBS;
        end else begin
            src_sel = SRC_FIFO;
        end

        if (load) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            case (src_sel)
                SRC_PRBS: begin
`ifdef SERDESPHY_TX_PRBS_EN
                    shreg_d     = prbs_word;
                    idle_word_d = 1'b0;
                    prbs_d      = prbs_adv;
`else
                    shreg_d     = IDLE_PAT;
                    idle_word_d = 1'b1;
`endif
                end
                SRC_FIFO: begin
                    if (!tx_fifo_empty) begin
                        shreg_d     = fifo_rd_data;
                        idle_word_d = 1'b0;
                        fifo_pop    = 1'b1;
                    end else begin
                        shreg_d       = IDLE_PAT;
                        idle_word_d   = 1'b1;
                        underflow_set = popped_eff;
                    end
                end
                default: begin
                    shreg_d     = IDLE_PAT;
                    idle_word_d = 1'b1;
                end
            endcase
        end else if (state_q == StShift) begin
            if (word_end) begin
                state_d = StIdle;
            end else begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end

        popped_d    = popped_eff || fifo_pop;
        overflow_d  = (tx_valid && tx_fifo_full) || (overflow_q && !clr_sticky);
        underflow_d = underflow_set || (underflow_q && !clr_sticky);
    end

    always_ff @(posedge clk_240m_tx) begin
        if (rst_240m_tx) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            idle_word_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            popped_q    <= 1'b0;
            tx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_word_q <= idle_word_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            popped_q    <= popped_d;
            tx_en_q     <= tx_en;
        end
    end

    assign tx_active       = (state_q == StShift);
    assign tx_serial_valid = tx_active;
    assign tx_serial_data  = tx_active && shreg_q[0];
    assign tx_idle_pattern = tx_active && idle_word_q;
    assign tx_ready        = !tx_fifo_full;
    assign tx_overflow     = overflow_q;
    assign tx_underflow    = underflow_q;

endmodule
